peridot_phy_uart_fifo: RTL and testbench
========================================

Name: peridot_phy_uart_fifo

Overview:
Next-generation host UART physical layer. It combines the receiver, the transmitter and FIFO buffering in both directions into one parametrised block. Received bytes appear on an Avalon-ST source; bytes to transmit are taken from an Avalon-ST sink. The block adds framing-error detection, sticky overrun and error status, a configurable number of stop bits, and optional RTS/CTS flow control. It sits between the host UART pins and the config/packet layer.

Parameters:
- CLOCK_FREQUENCY, 100000000: clk frequency in Hz.
- UART_BAUDRATE, 115200: line rate. BIT_CYCLE = CLOCK_FREQUENCY/UART_BAUDRATE (integer division). Elaboration fails if BIT_CYCLE < 16.
- RXFIFO_DEPTH, 6: log2 of the receive FIFO word count (64 words).
- TXFIFO_DEPTH, 4: log2 of the transmit FIFO word count (16 words).
- STOP_BITS, 1: 1 or 2. Applies to transmit only; the receiver checks one stop bit.
- RTS_THRESHOLD, 48: rx FIFO used-word level at which rts_n deasserts (used only with the optional feature).

Ports:
- clk  in  1  single clock; every flop uses its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous: flush both FIFOs, clear sticky flags, abort the receive frame.
- rxd  in  1  serial input, asynchronous to clk.
- txd  out  1  serial output; idles high.
- out_ready  in  1  rx stream sink ready.
- out_valid  out  1  rx byte available.
- out_data  out  8  rx byte (show-ahead).
- in_ready  out  1  tx FIFO not full.
- in_valid  in  1  tx byte offered.
- in_data  in  8  tx byte.
- rx_usedw  out  RXFIFO_DEPTH+1  rx FIFO occupancy, 0..2^RXFIFO_DEPTH.
- rx_overrun  out  1  sticky: a received byte was dropped because the rx FIFO was full.
- rx_frameerr  out  1  sticky: a stop bit was sampled low.
- tx_empty  out  1  tx FIFO empty and tx shifter idle.
- rts_n  out  1  present only with PERIDOT_UART_RTSCTS_EN.
- cts_n  in  1  present only with PERIDOT_UART_RTSCTS_EN.

Behaviour:
- Reset values: txd=1, out_valid=0, out_data=0, in_ready=1, rx_usedw=0, both sticky flags 0, tx_empty=1, rts_n=0. Both FIFOs are empty after reset.
- rxd synchroniser: 2-FF, reset to 1.
- Receive FSM, states RX_IDLE, RX_START, RX_DATA, RX_STOP:
  - RX_IDLE -> RX_START on a synchronised falling edge.
  - RX_START waits BIT_CYCLE/2 and resamples. If rxd is high, the start is a glitch: return to RX_IDLE.
  - RX_DATA samples 8 bits, LSB first, every BIT_CYCLE.
  - RX_STOP samples once. High: push the byte. Low: set rx_frameerr, drop the byte, then wait for rxd high before RX_IDLE.
- Receive push timing: the byte is written in the cycle after the stop sample, and out_valid rises on the following cycle.
- Receive FIFO full:
  - A push while full with no pop in the same cycle drops the byte and sets rx_overrun.
  - A push and a pop in the same cycle while full are both accepted; occupancy is unchanged.
- Rx stream handshake: a pop occurs when out_valid and out_ready are both high. out_data holds its value while out_valid is high and out_ready is low.
- Tx stream handshake: a byte is accepted when in_valid and in_ready are both high. A push while full cannot happen because in_ready is low.
- Transmit FSM, states TX_IDLE, TX_START, TX_DATA, TX_STOP:
  - TX_IDLE loads from the FIFO when it is non-empty.
  - The start bit begins 2 cycles after the load.
  - Frame: 1 start bit, 8 data bits LSB first, STOP_BITS stop bits, each BIT_CYCLE cycles long.
  - Back-to-back bytes are sent with no idle gap.
- clear: empties both FIFOs. A tx frame already in progress completes. The rx FSM returns to RX_IDLE. Flags clear in the same cycle. If clear coincides with an error event, clear wins.
- reset_n asserted mid-frame: txd returns to 1 immediately, which is asynchronous and may truncate the frame.

Optional Feature:
- PERIDOT_UART_RTSCTS_EN defined:
  - rts_n is registered. It goes to 1 when rx_usedw >= RTS_THRESHOLD and back to 0 when rx_usedw < RTS_THRESHOLD-8.
  - cts_n passes through a 2-FF synchroniser. While it is high, TX_IDLE does not load a new byte; a frame already in progress completes.
- Not defined: rts_n and cts_n ports are absent, and the transmitter ignores flow control.

Decomposition:
- Package peridot_uart_pkg: rx/tx state encodings, a BIT_CYCLE calculation function, and the minimum-BIT_CYCLE constant (16).
- One sub-module, peridot_uart_sync_fifo: parametrised width/depth, show-ahead, with usedw, full and empty outputs. It is instantiated twice.

Test Plan:
- 100 MHz clock, 115200 baud (BIT_CYCLE=868); drive 0x55 on rxd -> out_valid with out_data=0x55, rx_usedw=1, no flags.
- Frame 0xA5 with the stop bit low -> no push, rx_frameerr=1; pulse clear -> rx_frameerr=0.
- out_ready=0; send 65 bytes 0x00..0x40 with RXFIFO_DEPTH=6 -> rx_usedw=64, rx_overrun=1; draining yields 0x00..0x3F in order.
- Push 0x3C then 0xC3 -> txd shows start, 0,0,1,1,1,1,0,0, stop, then the next frame with no gap; each bit lasts 868 cycles. tx_empty=1 after the final stop bit.
- Assert reset_n low mid-rx and mid-tx -> txd=1 at once; after release no spurious byte appears and out_valid=0.
- With the macro defined: fill rx to 48 -> rts_n=1; drain to 39 -> rts_n=0. cts_n=1 during a frame -> the frame finishes and the next byte is held until cts_n=0.

Source files
------------

// File: rtl/peridot_uart_pkg.sv
// -----------------------------------------------------------------------------
// peridot_uart_pkg
// Shared definitions for the peridot host UART physical layer:
//   - receive / transmit FSM state encodings
//   - bit-period calculation from clock frequency and baud rate
//   - minimum legal bit period (16 clocks)
// -----------------------------------------------------------------------------
package peridot_uart_pkg;

  localparam int MIN_BIT_CYCLE = 16;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  // Clocks per serial bit (integer division, truncating)
  function automatic int calc_bit_cycle(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/peridot_uart_sync_fifo.sv
// -----------------------------------------------------------------------------
// peridot_uart_sync_fifo
// Single-clock show-ahead FIFO, 2**DEPTH words of WIDTH bits.
// Ports:
//   clk, reset_n (async active-low), clear (sync flush)
//   wr_en/wr_data  : write; accepted when not full, or when full and a read
//                    is accepted in the same cycle
//   rd_en/rd_data  : read; rd_data shows the head word (0 when empty)
//   usedw          : occupancy 0..2**DEPTH
//   full, empty    : status
// -----------------------------------------------------------------------------
module peridot_uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [DEPTH:0]   usedw,
  output logic             full,
  output logic             empty
);

  localparam int WORDS = 1 << DEPTH;

  logic [WIDTH-1:0] mem_q [WORDS];
  logic [DEPTH-1:0] wr_ptr_q;
  logic [DEPTH-1:0] rd_ptr_q;
  logic [DEPTH:0]   count_q;
  logic             wr_ok_s;
  logic             rd_ok_s;

  assign empty   = (count_q == {(DEPTH+1){1'b0}});
  // count never exceeds WORDS, so its MSB alone marks full
  assign full    = count_q[DEPTH];
  assign usedw   = count_q;
  assign rd_ok_s = rd_en && !empty;
  // when full, a simultaneous read frees the slot being written
  assign wr_ok_s = wr_en && (!full || rd_ok_s);
  assign rd_data = empty ? {WIDTH{1'b0}} : mem_q[rd_ptr_q];

  // storage array, no reset needed (contents are masked while empty)
  always_ff @(posedge clk) begin
    if (wr_ok_s && !clear) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // pointers and occupancy counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= {DEPTH{1'b0}};
      rd_ptr_q <= {DEPTH{1'b0}};
      count_q  <= {(DEPTH+1){1'b0}};
    end else if (clear) begin
      wr_ptr_q <= {DEPTH{1'b0}};
      rd_ptr_q <= {DEPTH{1'b0}};
      count_q  <= {(DEPTH+1){1'b0}};
    end else begin
      if (wr_ok_s) begin
        wr_ptr_q <= wr_ptr_q + DEPTH'(1);
      end
      if (rd_ok_s) begin
        rd_ptr_q <= rd_ptr_q + DEPTH'(1);
      end
      case ({wr_ok_s, rd_ok_s})
        2'b10:   count_q <= count_q + (DEPTH+1)'(1);
        2'b01:   count_q <= count_q - (DEPTH+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/peridot_phy_uart_fifo.sv
// -----------------------------------------------------------------------------
// peridot_phy_uart_fifo
// Host UART physical layer: receiver + transmitter with FIFOs both ways.
// Ports:
//   clk, reset_n (async active-low), clear (sync flush of FIFOs/flags/rx FSM)
//   rxd / txd                     : serial line (txd idles high)
//   out_valid/out_ready/out_data  : Avalon-ST source of received bytes
//   in_valid/in_ready/in_data     : Avalon-ST sink of bytes to transmit
//   rx_usedw                      : rx FIFO occupancy
//   rx_overrun, rx_frameerr       : sticky status, cleared by clear
//   tx_empty                      : tx FIFO empty and transmitter idle
//   rts_n / cts_n                 : flow control, only when the macro
//                                   PERIDOT_UART_RTSCTS_EN is defined
// -----------------------------------------------------------------------------
module peridot_phy_uart_fifo
  import peridot_uart_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 100000000,
  parameter int UART_BAUDRATE   = 115200,
  parameter int RXFIFO_DEPTH    = 6,
  parameter int TXFIFO_DEPTH    = 4,
  parameter int STOP_BITS       = 1,
  parameter int RTS_THRESHOLD   = 48
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  rxd,
  output logic                  txd,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [7:0]            out_data,
  output logic                  in_ready,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic [RXFIFO_DEPTH:0] rx_usedw,
  output logic                  rx_overrun,
  output logic                  rx_frameerr,
  output logic                  tx_empty
`ifdef PERIDOT_UART_RTSCTS_EN
  ,
  output logic                  rts_n,
  input  logic                  cts_n
`endif
);

  localparam int BIT_CYCLE = calc_bit_cycle(CLOCK_FREQUENCY, UART_BAUDRATE);
  localparam int CNT_W     = $clog2(BIT_CYCLE * 2);
  localparam int UW        = RXFIFO_DEPTH + 1;
  localparam int TUW       = TXFIFO_DEPTH + 1;

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLE - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_CYCLE / 2 - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(BIT_CYCLE * STOP_BITS - 1);

  if (BIT_CYCLE < MIN_BIT_CYCLE) begin : g_bad_bit_cycle
    $error("peridot_phy_uart_fifo: BIT_CYCLE below minimum");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("peridot_phy_uart_fifo: STOP_BITS must be 1 or 2");
  end
  if (RTS_THRESHOLD < 8 || RTS_THRESHOLD > (1 << RXFIFO_DEPTH)) begin : g_bad_rts
    $error("peridot_phy_uart_fifo: RTS_THRESHOLD out of range");
  end

  // ---------------------------------------------------------------- receive
  logic       rxd_meta_q, rxd_sync_q, rxd_prev_q;
  logic       rxd_fall_s;
  rx_state_t  rx_state_q;
  logic [CNT_W-1:0] rx_cnt_q;
  logic [2:0] rx_bit_q;
  logic [7:0] rx_shreg_q;
  logic       rx_push_q;
  logic       rx_wait_high_q;
  logic       rx_frameerr_q;
  logic       rx_overrun_q;
  logic       rx_pop_s;
  logic       rx_empty_s;
  logic       rx_full_s;
  logic       rx_overrun_evt_s;

  // rxd 2-FF synchroniser plus one delayed copy for falling-edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      rxd_meta_q <= rxd;
      rxd_sync_q <= rxd_meta_q;
      rxd_prev_q <= rxd_sync_q;
    end
  end

  assign rxd_fall_s = rxd_prev_q && !rxd_sync_q;

  // receive FSM; rx_push_q is a one-cycle write strobe issued after a good stop
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state_q     <= RX_IDLE;
      rx_cnt_q       <= CNT_ZERO;
      rx_bit_q       <= 3'd0;
      rx_shreg_q     <= 8'h00;
      rx_push_q      <= 1'b0;
      rx_wait_high_q <= 1'b0;
      rx_frameerr_q  <= 1'b0;
    end else if (clear) begin
      rx_state_q     <= RX_IDLE;
      rx_push_q      <= 1'b0;
      rx_wait_high_q <= 1'b0;
      rx_frameerr_q  <= 1'b0;
    end else begin
      rx_push_q <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          if (rxd_fall_s) begin
            rx_cnt_q   <= HALF_LAST;
            rx_state_q <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt_q == CNT_ZERO) begin
            // line back high at mid start bit: treat as a glitch
            if (rxd_sync_q) begin
              rx_state_q <= RX_IDLE;
            end else begin
              rx_cnt_q   <= BIT_LAST;
              rx_bit_q   <= 3'd0;
              rx_state_q <= RX_DATA;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q - CNT_ONE;
          end
        end
        RX_DATA: begin
          if (rx_cnt_q == CNT_ZERO) begin
            rx_shreg_q <= {rxd_sync_q, rx_shreg_q[7:1]};
            rx_cnt_q   <= BIT_LAST;
            rx_bit_q   <= rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) begin
              rx_state_q <= RX_STOP;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q - CNT_ONE;
          end
        end
        RX_STOP: begin
          if (rx_wait_high_q) begin
            // after a framing error, hold off until the line is idle again
            if (rxd_sync_q) begin
              rx_wait_high_q <= 1'b0;
              rx_state_q     <= RX_IDLE;
            end
          end else if (rx_cnt_q == CNT_ZERO) begin
            if (rxd_sync_q) begin
              rx_push_q  <= 1'b1;
              rx_state_q <= RX_IDLE;
            end else begin
              rx_frameerr_q  <= 1'b1;
              rx_wait_high_q <= 1'b1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q - CNT_ONE;
          end
        end
        default: begin
          rx_state_q <= RX_IDLE;
        end
      endcase
    end
  end

  assign rx_pop_s         = out_valid && out_ready;
  assign rx_overrun_evt_s = rx_push_q && rx_full_s && !rx_pop_s;
  assign out_valid        = !rx_empty_s;
  assign rx_frameerr      = rx_frameerr_q;
  assign rx_overrun       = rx_overrun_q;

  // sticky overrun flag; clear takes priority over a coincident drop
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_overrun_q <= 1'b0;
    end else if (clear) begin
      rx_overrun_q <= 1'b0;
    end else if (rx_overrun_evt_s) begin
      rx_overrun_q <= 1'b1;
    end
  end

  peridot_uart_sync_fifo #(
    .WIDTH (8),
    .DEPTH (RXFIFO_DEPTH)
  ) u_rx_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .wr_en   (rx_push_q),
    .wr_data (rx_shreg_q),
    .rd_en   (rx_pop_s),
    .rd_data (out_data),
    .usedw   (rx_usedw),
    .full    (rx_full_s),
    .empty   (rx_empty_s)
  );

  // --------------------------------------------------------- flow control
  logic cts_ok_s;

`ifdef PERIDOT_UART_RTSCTS_EN
  localparam logic [UW-1:0] RTS_HI = UW'(RTS_THRESHOLD);
  localparam logic [UW-1:0] RTS_LO = UW'(RTS_THRESHOLD - 8);

  logic rts_q;
  logic cts_meta_q, cts_sync_q;

  // rts_n with hysteresis: assert stop at RTS_HI, release below RTS_LO
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rts_q <= 1'b0;
    end else if (rx_usedw >= RTS_HI) begin
      rts_q <= 1'b1;
    end else if (rx_usedw < RTS_LO) begin
      rts_q <= 1'b0;
    end
  end

  // cts_n 2-FF synchroniser; resets to "stop" until the peer is seen
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cts_meta_q <= 1'b1;
      cts_sync_q <= 1'b1;
    end else begin
      cts_meta_q <= cts_n;
      cts_sync_q <= cts_meta_q;
    end
  end

  assign rts_n    = rts_q;
  assign cts_ok_s = !cts_sync_q;
`else
  assign cts_ok_s = 1'b1;
`endif

  // --------------------------------------------------------------- transmit
  tx_state_t        tx_state_q;
  logic [CNT_W-1:0] tx_cnt_q;
  logic [2:0]       tx_bit_q;
  logic [7:0]       tx_shreg_q;
  logic             txd_q;
  logic             tx_empty_q;
  logic             tx_load_s;
  logic             tx_full_s;
  logic             tx_fifo_empty_s;
  logic [7:0]       tx_rd_data_s;
  logic [TUW-1:0]   tx_usedw_s;

  assign in_ready = !tx_full_s;

  // a new byte may be taken when idle or in the last cycle of the stop bits
  assign tx_load_s = ((tx_state_q == TX_IDLE) ||
                      ((tx_state_q == TX_STOP) && (tx_cnt_q == CNT_ZERO))) &&
                     !tx_fifo_empty_s && !clear && cts_ok_s;

  // transmit FSM; txd_q is set one cycle ahead so the start bit begins
  // two cycles after the load
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= CNT_ZERO;
      tx_bit_q   <= 3'd0;
      tx_shreg_q <= 8'h00;
      txd_q      <= 1'b1;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          txd_q <= 1'b1;
          if (tx_load_s) begin
            tx_shreg_q <= tx_rd_data_s;
            tx_cnt_q   <= BIT_LAST;
            tx_state_q <= TX_START;
          end
        end
        TX_START: begin
          txd_q <= 1'b0;
          if (tx_cnt_q == CNT_ZERO) begin
            tx_cnt_q   <= BIT_LAST;
            tx_bit_q   <= 3'd0;
            tx_state_q <= TX_DATA;
          end else begin
            tx_cnt_q <= tx_cnt_q - CNT_ONE;
          end
        end
        TX_DATA: begin
          txd_q <= tx_shreg_q[0];
          if (tx_cnt_q == CNT_ZERO) begin
            tx_shreg_q <= {1'b0, tx_shreg_q[7:1]};
            tx_bit_q   <= tx_bit_q + 3'd1;
            if (tx_bit_q == 3'd7) begin
              tx_cnt_q   <= STOP_LAST;
              tx_state_q <= TX_STOP;
            end else begin
              tx_cnt_q <= BIT_LAST;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q - CNT_ONE;
          end
        end
        TX_STOP: begin
          txd_q <= 1'b1;
          if (tx_cnt_q == CNT_ZERO) begin
            if (tx_load_s) begin
              tx_shreg_q <= tx_rd_data_s;
              tx_cnt_q   <= BIT_LAST;
              tx_state_q <= TX_START;
            end else begin
              tx_state_q <= TX_IDLE;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q - CNT_ONE;
          end
        end
        default: begin
          txd_q      <= 1'b1;
          tx_state_q <= TX_IDLE;
        end
      endcase
    end
  end

  // idle indicator: nothing queued and the shifter has finished
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_empty_q <= 1'b1;
    end else begin
      tx_empty_q <= (tx_usedw_s == {TUW{1'b0}}) && (tx_state_q == TX_IDLE);
    end
  end

  assign txd      = txd_q;
  assign tx_empty = tx_empty_q;

  peridot_uart_sync_fifo #(
    .WIDTH (8),
    .DEPTH (TXFIFO_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .wr_en   (in_valid && in_ready),
    .wr_data (in_data),
    .rd_en   (tx_load_s),
    .rd_data (tx_rd_data_s),
    .usedw   (tx_usedw_s),
    .full    (tx_full_s),
    .empty   (tx_fifo_empty_s)
  );

endmodule

// File: tb/tb_peridot_phy_uart_fifo.sv
// -----------------------------------------------------------------------------
// tb_peridot_phy_uart_fifo
// Directed bench for peridot_phy_uart_fifo with a 16-clock bit period.
// A table of receive frames is applied in a loop; overrun, transmit framing,
// asynchronous reset and (with PERIDOT_UART_RTSCTS_EN) flow control are
// exercised by hand-written sequences.
// -----------------------------------------------------------------------------
module tb_peridot_phy_uart_fifo;

  localparam int CLK_HZ = 1600000;
  localparam int BAUD   = 100000;
  localparam int BC     = 16;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       clear;
  logic       rxd;
  logic       txd;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       in_ready;
  logic       in_valid;
  logic [7:0] in_data;
  logic [6:0] rx_usedw;
  logic       rx_overrun;
  logic       rx_frameerr;
  logic       tx_empty;
`ifdef PERIDOT_UART_RTSCTS_EN
  logic       rts_n;
  logic       cts_n;
`endif

  int n_vec = 0;
  int n_err = 0;

  peridot_phy_uart_fifo #(
    .CLOCK_FREQUENCY (CLK_HZ),
    .UART_BAUDRATE   (BAUD),
    .RXFIFO_DEPTH    (6),
    .TXFIFO_DEPTH    (4),
    .STOP_BITS       (1),
    .RTS_THRESHOLD   (48)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear       (clear),
    .rxd         (rxd),
    .txd         (txd),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .in_ready    (in_ready),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .rx_usedw    (rx_usedw),
    .rx_overrun  (rx_overrun),
    .rx_frameerr (rx_frameerr),
    .tx_empty    (tx_empty)
`ifdef PERIDOT_UART_RTSCTS_EN
    ,
    .rts_n       (rts_n),
    .cts_n       (cts_n)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_ferr;
  } rx_vec_t;

  rx_vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // one serial frame on rxd followed by one idle bit time
  task automatic send_rx(input logic [7:0] b, input logic stop);
    @(negedge clk) rxd = 1'b0;
    repeat (BC - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk) rxd = b[i];
      repeat (BC - 1) @(negedge clk);
    end
    @(negedge clk) rxd = stop;
    repeat (BC - 1) @(negedge clk);
    @(negedge clk) rxd = 1'b1;
    repeat (BC) @(negedge clk);
  endtask

  task automatic pop();
    @(negedge clk) out_ready = 1'b1;
    @(negedge clk) out_ready = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk) clear = 1'b1;
    @(negedge clk) clear = 1'b0;
  endtask

  task automatic push_tx(input logic [7:0] b);
    @(negedge clk) begin in_valid = 1'b1; in_data = b; end
    @(negedge clk) in_valid = 1'b0;
  endtask

  // bounded wait for a start bit on txd (sampled at negedge)
  task automatic wait_txd_low(input string name, input int limit);
    int t;
    t = 0;
    while (txd !== 1'b0 && t < limit) begin
      @(negedge clk);
      t++;
    end
    chk(name, 32'(txd), 32'd0);
  endtask

  // verify two back-to-back frames, first and last cycle of every bit,
  // starting at the first low cycle of the first start bit
  task automatic check_tx_pair(input logic [7:0] b0, input logic [7:0] b1);
    logic [19:0] bits;
    bits = {1'b1, b1, 1'b0, 1'b1, b0, 1'b0};
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("tx bit %0d first", k), 32'(txd), 32'(bits[k]));
      repeat (BC - 1) @(negedge clk);
      chk($sformatf("tx bit %0d last", k), 32'(txd), 32'(bits[k]));
      @(negedge clk);
    end
  endtask

  initial begin
    vecs[0] = '{8'h55, 1'b1, 1'b1, 8'h55, 1'b0};
    vecs[1] = '{8'hA5, 1'b0, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0};
    vecs[3] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0};
    vecs[4] = '{8'h81, 1'b1, 1'b1, 8'h81, 1'b0};
    vecs[5] = '{8'h3C, 1'b0, 1'b0, 8'h00, 1'b1};

    reset_n   = 1'b0;
    clear     = 1'b0;
    rxd       = 1'b1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
`ifdef PERIDOT_UART_RTSCTS_EN
    cts_n     = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("reset txd",         32'(txd),         32'd1);
    chk("reset out_valid",   32'(out_valid),   32'd0);
    chk("reset out_data",    32'(out_data),    32'd0);
    chk("reset in_ready",    32'(in_ready),    32'd1);
    chk("reset rx_usedw",    32'(rx_usedw),    32'd0);
    chk("reset rx_overrun",  32'(rx_overrun),  32'd0);
    chk("reset rx_frameerr", 32'(rx_frameerr), 32'd0);
    chk("reset tx_empty",    32'(tx_empty),    32'd1);
`ifdef PERIDOT_UART_RTSCTS_EN
    chk("reset rts_n",       32'(rts_n),       32'd0);
`endif
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // table-driven receive frames
    for (int v = 0; v < 6; v++) begin
      send_rx(vecs[v].data, vecs[v].stop);
      chk($sformatf("vec%0d out_valid", v),   32'(out_valid),   32'(vecs[v].exp_valid));
      chk($sformatf("vec%0d out_data", v),    32'(out_data),    32'(vecs[v].exp_data));
      chk($sformatf("vec%0d rx_usedw", v),    32'(rx_usedw),    32'(vecs[v].exp_valid));
      chk($sformatf("vec%0d rx_frameerr", v), 32'(rx_frameerr), 32'(vecs[v].exp_ferr));
      chk($sformatf("vec%0d rx_overrun", v),  32'(rx_overrun),  32'd0);
      if (vecs[v].exp_valid) begin
        pop();
        chk($sformatf("vec%0d drained", v), 32'(out_valid), 32'd0);
      end
      if (vecs[v].exp_ferr) begin
        pulse_clear();
        chk($sformatf("vec%0d ferr cleared", v), 32'(rx_frameerr), 32'd0);
      end
    end

    // short low glitch on rxd must not start a frame
    @(negedge clk) rxd = 1'b0;
    repeat (3) @(negedge clk);
    rxd = 1'b1;
    repeat (12 * BC) @(negedge clk);
    chk("glitch no byte", 32'(out_valid), 32'd0);

    // overrun: 65 bytes into a 64-word FIFO with the sink stalled
    for (int i = 0; i < 65; i++) begin
      send_rx(8'(i), 1'b1);
    end
    chk("full rx_usedw",   32'(rx_usedw),   32'd64);
    chk("full rx_overrun", 32'(rx_overrun), 32'd1);
    chk("full out_valid",  32'(out_valid),  32'd1);
    out_ready = 1'b0;
    @(negedge clk);
    chk("stall holds data", 32'(out_data), 32'd0);
    for (int i = 0; i < 64; i++) begin
      chk($sformatf("drain %0d", i), 32'(out_data), 32'(i));
      pop();
    end
    chk("drained out_valid", 32'(out_valid),  32'd0);
    chk("drained rx_usedw",  32'(rx_usedw),   32'd0);
    chk("overrun sticky",    32'(rx_overrun), 32'd1);
    pulse_clear();
    chk("overrun cleared",   32'(rx_overrun), 32'd0);

    // transmit two back-to-back frames
    @(negedge clk) begin in_valid = 1'b1; in_data = 8'h3C; end
    @(negedge clk) in_data = 8'hC3;
    @(negedge clk) in_valid = 1'b0;
    wait_txd_low("tx first start", 20);
    chk("tx busy tx_empty", 32'(tx_empty), 32'd0);
    check_tx_pair(8'h3C, 8'hC3);
    repeat (2) @(negedge clk);
    chk("tx done tx_empty", 32'(tx_empty), 32'd1);
    chk("tx done idle txd", 32'(txd),      32'd1);

    // asynchronous reset during a tx frame and an rx frame
    push_tx(8'h00);
    wait_txd_low("tx start before reset", 20);
    rxd = 1'b0;
    repeat (2 * BC) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("async reset txd",      32'(txd),      32'd1);
    chk("async reset tx_empty", 32'(tx_empty), 32'd1);
    repeat (2) @(negedge clk);
    rxd     = 1'b1;
    reset_n = 1'b1;
    repeat (12 * BC) @(negedge clk);
    chk("post reset out_valid", 32'(out_valid), 32'd0);
    chk("post reset rx_usedw",  32'(rx_usedw),  32'd0);
    chk("post reset txd",       32'(txd),       32'd1);
    chk("post reset tx_empty",  32'(tx_empty),  32'd1);

`ifdef PERIDOT_UART_RTSCTS_EN
    // rts_n hysteresis
    for (int i = 0; i < 47; i++) begin
      send_rx(8'(i), 1'b1);
    end
    chk("rts below threshold", 32'(rts_n), 32'd0);
    send_rx(8'd47, 1'b1);
    chk("rts at threshold", 32'(rts_n), 32'd1);
    for (int i = 0; i < 8; i++) begin
      pop();
    end
    @(negedge clk);
    chk("rts hold at 40", 32'(rts_n), 32'd1);
    pop();
    @(negedge clk);
    chk("rts release at 39", 32'(rts_n), 32'd0);
    pulse_clear();

    // cts_n raised mid-frame: frame completes, next byte held
    @(negedge clk) begin in_valid = 1'b1; in_data = 8'h5A; end
    @(negedge clk) in_data = 8'h96;
    @(negedge clk) in_valid = 1'b0;
    wait_txd_low("cts frame start", 20);
    cts_n = 1'b1;
    repeat (10 * BC) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      repeat (BC) @(negedge clk);
      chk($sformatf("cts held idle %0d", i), 32'(txd), 32'd1);
    end
    chk("cts held tx_empty", 32'(tx_empty), 32'd0);
    cts_n = 1'b0;
    wait_txd_low("cts resume start", 20);
    repeat (12 * BC) @(negedge clk);
    chk("cts resumed tx_empty", 32'(tx_empty), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
